// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the RV32IF memory stage.
//   mem_state_t : bus-access FSM states (IDLE, REQ, WAIT, DONE)
//   XLEN_DEF    : default data/address width
package mem_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

endpackage

// File: rtl/dmem_if_fsm.sv
// dmem_if_fsm: data-memory bus sequencer for the memory stage.
// Captures the pending load/store, drives the req/gnt/rvalid bus, holds the
// returned load word and raises the pipeline stall while an access is open.
// Optional feature: define DMEM_ALIGN_CHECK_EN to trap misaligned accesses.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   re_i, we_i           load / store request of the instruction in execute
//   addr_i, wdata_i      access address and store data (execute registers)
//   stall_o              pipeline hold request
//   dmem_*               data-memory bus
//   ld_q_o               last load word
//   misalign_err_o       sticky misaligned-access flag
module dmem_if_fsm import mem_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            re_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [XLEN-1:0] ld_q_o,
  output logic            misalign_err_o
);

  mem_state_t      state_q, state_d;
  logic            pend_ld_q, pend_ld_d;
  logic            pend_st_q, pend_st_d;
  logic [XLEN-1:0] ld_q, ld_d;
  logic            pend;
  logic            req;
  logic            misalign;

  assign pend    = pend_ld_q | pend_st_q;
  // Registered-only decode: no path from gnt/rvalid to the stall.
  assign stall_o = pend && (state_q != DONE);

`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign misalign = (addr_i[1:0] != 2'b00);
  assign mis_d    = mis_q | ((state_q == IDLE) && pend && misalign);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end
  assign misalign_err_o = mis_q;
`else
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_i[1:0];
  assign misalign       = 1'b0;
  assign misalign_err_o = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ld_d      = ld_q;
    req       = 1'b0;
    // A new access is only taken while the pipeline is moving; DONE never
    // stalls, so the next access is captured on the DONE edge.
    pend_ld_d = stall_o ? pend_ld_q : re_i;
    pend_st_d = stall_o ? pend_st_q : we_i;
    unique case (state_q)
      IDLE: begin
        if (pend) begin
          if (misalign) begin
            state_d = DONE;
            if (pend_ld_q) ld_d = '0;
          end else begin
            req = 1'b1;
            if (dmem_gnt_i) state_d = pend_ld_q ? WAIT : DONE;
            else            state_d = REQ;
          end
        end
      end
      REQ: begin
        req = 1'b1;
        if (dmem_gnt_i) state_d = pend_ld_q ? WAIT : DONE;
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          ld_d    = dmem_rdata_i;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pend_ld_q <= 1'b0;
      pend_st_q <= 1'b0;
      ld_q      <= '0;
    end else begin
      state_q   <= state_d;
      pend_ld_q <= pend_ld_d;
      pend_st_q <= pend_st_d;
      ld_q      <= ld_d;
    end
  end

  // Load wins when both flags are set.
  assign dmem_req_o   = req;
  assign dmem_we_o    = req & pend_st_q & ~pend_ld_q;
  assign dmem_addr_o  = req ? {addr_i[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata_o = dmem_we_o ? wdata_i : '0;
  assign ld_q_o       = ld_q;

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage of the RV32IF pipeline.
// Performs execute-stage loads/stores on the data-memory bus (via
// dmem_if_fsm), stalls the pipeline while an access is outstanding and
// registers the writeback bundle for the register-file stage.
// Optional feature: define DMEM_ALIGN_CHECK_EN to trap misaligned accesses.
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   RE_mem, WE_mem                load / store request
//   exe_result_ex, op2_ex         access address / ALU result, store data
//   Load_ex, WE_reg, WE_freg      execute-stage flags
//   rd_addr_ex                    destination register
//   Stall                         pipeline hold
//   dmem_*                        data-memory bus
//   wb_data, WE_reg_mem,
//   WE_freg_mem, rd_addr_mem      writeback bundle
//   misalign_err                  sticky misaligned-access flag
module mem_access import mem_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            RE_mem,
  input  logic            WE_mem,
  input  logic [XLEN-1:0] exe_result_ex,
  input  logic [XLEN-1:0] op2_ex,
  input  logic            Load_ex,
  input  logic            WE_reg,
  input  logic            WE_freg,
  input  logic [4:0]      rd_addr_ex,
  output logic            Stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] wb_data,
  output logic            WE_reg_mem,
  output logic            WE_freg_mem,
  output logic [4:0]      rd_addr_mem,
  output logic            misalign_err
);

  logic [XLEN-1:0] ld_q;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            we_reg_q, we_reg_d;
  logic            we_freg_q, we_freg_d;
  logic [4:0]      rd_addr_q, rd_addr_d;

  dmem_if_fsm #(
    .XLEN(XLEN)
  ) u_fsm (
    .clk_i          (CLK),
    .rst_i          (RST),
    .re_i           (RE_mem),
    .we_i           (WE_mem),
    .addr_i         (exe_result_ex),
    .wdata_i        (op2_ex),
    .stall_o        (Stall),
    .dmem_req_o     (dmem_req),
    .dmem_we_o      (dmem_we),
    .dmem_addr_o    (dmem_addr),
    .dmem_wdata_o   (dmem_wdata),
    .dmem_gnt_i     (dmem_gnt),
    .dmem_rvalid_i  (dmem_rvalid),
    .dmem_rdata_i   (dmem_rdata),
    .ld_q_o         (ld_q),
    .misalign_err_o (misalign_err)
  );

  always_comb begin
    wb_data_d = wb_data_q;
    we_reg_d  = we_reg_q;
    we_freg_d = we_freg_q;
    rd_addr_d = rd_addr_q;
    if (!Stall) begin
      wb_data_d = Load_ex ? ld_q : exe_result_ex;
      we_reg_d  = WE_reg;
      we_freg_d = WE_freg;
      rd_addr_d = rd_addr_ex;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb_data_q <= '0;
      we_reg_q  <= 1'b0;
      we_freg_q <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      wb_data_q <= wb_data_d;
      we_reg_q  <= we_reg_d;
      we_freg_q <= we_freg_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign wb_data     = wb_data_q;
  assign WE_reg_mem  = we_reg_q;
  assign WE_freg_mem = we_freg_q;
  assign rd_addr_mem = rd_addr_q;

endmodule

// File: doc/mem_access.md
# mem_access

Memory stage of the RV32IF pipeline. It sits downstream of the execute stage: it takes the load/store requests that execute issues (read/write enables, address, store data) and performs them on a single-port data-memory bus with a request/grant/rvalid handshake. While an access is outstanding it drives `Stall` back to the pipeline. It also registers the writeback bundle (result, write enables, destination register) for the register-file stage.

## Interface
- `XLEN`, default 32: data and address width.
- `CLK`  in  1: clock; all state updates on the rising edge.
- `RST`  in  1: asynchronous reset, active-high.
- `RE_mem`, `WE_mem`  in  1 each: load / store request for the instruction in execute. Already gated by flush upstream.
- `exe_result_ex`  in  XLEN: registered ALU result; this is the access address for loads and stores.
- `op2_ex`  in  XLEN: registered store data.
- `Load_ex`, `WE_reg`, `WE_freg`  in  1 each: execute-stage pipeline flags.
- `rd_addr_ex`  in  5: destination register.
- `Stall`  out  1: pipeline hold request.
- `dmem_req`, `dmem_we`  out  1 each: bus request and its write qualifier.
- `dmem_addr`, `dmem_wdata`  out  XLEN: bus address and store data.
- `dmem_gnt`, `dmem_rvalid`  in  1 each: request accepted / read data valid.
- `dmem_rdata`  in  XLEN: read data.
- `wb_data`  out  XLEN: writeback value.
- `WE_reg_mem`, `WE_freg_mem`  out  1 each: writeback enables.
- `rd_addr_mem`  out  5: writeback destination.
- `misalign_err`  out  1: sticky misaligned-access flag.

## Operation
- **Capture.** On each edge with `Stall`=0, register `pend_ld <= RE_mem` and `pend_st <= WE_mem`. Both set is illegal; load wins.
- **FSM states:** IDLE, REQ, WAIT, DONE.
- **IDLE**
  - With `pend_ld|pend_st`=0: no bus activity.
  - Otherwise behave as REQ in the same cycle: `dmem_req`=1, `dmem_we`=`pend_st`.
- **REQ**
  - Hold `dmem_req`, `dmem_addr`, `dmem_we`, `dmem_wdata` stable until `dmem_gnt`=1.
  - On grant: a store goes to DONE; a load goes to WAIT.
- **WAIT**
  - `dmem_req`=0.
  - On `dmem_rvalid`: capture `dmem_rdata` into `ld_q` and go to DONE.
- **DONE**
  - No bus activity; `Stall`=0 this cycle.
  - Clear `pend_*`, then go to IDLE.
- **Stall** = `(pend_ld|pend_st)` and state != DONE. Decoded from registered state only; no combinational path from `dmem_gnt` or `dmem_rvalid`.
- **Writeback registers** update when `Stall`=0, otherwise hold:
  - `wb_data <= Load_ex ? ld_q : exe_result_ex`
  - `WE_reg_mem`, `WE_freg_mem`, `rd_addr_mem` copy their execute-stage inputs.
- `rvalid` arriving in IDLE, REQ or DONE is ignored.
- **Reset values:** state=IDLE, `pend_*`=0, `ld_q`=0, `Stall`=0, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `wb_data`=0, `WE_reg_mem`=0, `WE_freg_mem`=0, `rd_addr_mem`=0, `misalign_err`=0.
- **Reset mid-access:** `dmem_req` drops immediately (asynchronous). Any grant or rvalid belonging to the aborted access is ignored.

## Timing
- **Store, grant in first cycle:** 1 stall cycle (IDLE/REQ), then DONE. The pipeline advances at the end of the DONE cycle.
- **Load:** rvalid comes at least 1 cycle after grant. Minimum is 2 stall cycles (REQ, WAIT), then DONE.
- **Each extra cycle** without grant or rvalid adds exactly one stall cycle.
- **Back-to-back accesses:** the next access is captured at the DONE edge. Its request can assert in the cycle right after DONE.
- **Non-memory instructions:** zero stall cycles.

## Configuration
- **`DMEM_ALIGN_CHECK_EN` defined:** when `exe_result_ex[1:0]`!=0 for a pending access:
  - no bus request is made and the FSM goes straight to DONE (1 stall cycle);
  - a load returns 0;
  - a store is dropped;
  - `misalign_err` is set and stays set until `RST`.
- **Undefined:** `dmem_addr` = `{addr[XLEN-1:2],2'b00}`, the access proceeds normally, and `misalign_err` is tied to 0.

## Structure
- **Package `mem_pkg`:** the state enum typedef `mem_state_t` (IDLE/REQ/WAIT/DONE) and the constant `XLEN_DEF`=32.
- **Sub-module `dmem_if_fsm`:** contains the FSM, the bus drive and `ld_q`; it outputs `Stall`. The writeback registers stay in `mem_access`.

## Test plan
- **Store with grant held high:** `WE_mem`=1, addr 0x100, data 0xDEADBEEF → `dmem_req`/`dmem_we` high for 1 cycle with those values; `Stall` high for exactly 1 cycle.
- **Load with rvalid 3 cycles after grant:** addr 0x104, `rdata` 0x12345678 → `Stall` high 4 cycles; then `wb_data`=0x12345678, `WE_reg_mem`=1, `rd_addr_mem`=5.
- **Grant withheld 2 cycles:** address and data stay stable while `dmem_req` is high; `Stall` is 2 cycles longer than the baseline.
- **ALU op (`RE_mem`=`WE_mem`=0):** `Stall` never asserts; `wb_data` = `exe_result_ex` one cycle later.
- **Reset during WAIT:** `RST` pulse, then a stray `rvalid` → outputs hold reset values and `wb_data` is unchanged.
- **With `DMEM_ALIGN_CHECK_EN` defined, load at 0x102:** no `dmem_req`; `wb_data`=0; `misalign_err`=1 and still set after 10 further cycles.
